sd_block_xfer: RTL

//  Multi-byte sector transfer engine between user logic and sd_spi_controller.

---
 rtl/sd_block_xfer_pkg.sv | 28 ++
 rtl/sd_block_xfer_sector_buf.sv | 39 +++
 rtl/sd_block_xfer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_xfer_pkg.sv
// Shared types for the SD block transfer engine: FSM state encoding,
// error codes and a width helper for index/counter sizing.
package sd_block_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_XFER_RD,
    ST_XFER_WR,
    ST_RETRY,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_SHORT   = 2'd2,
    ERR_NOTRDY  = 2'd3
  } err_t;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_block_xfer_sector_buf.sv
// Sector buffer: one write port, two registered read ports
// (user readback and the SD write-data path).
module sd_block_xfer_sector_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [IDX_W-1:0] i_raddr_a,
  output logic [7:0]       o_rdata_a,
  input  logic [IDX_W-1:0] i_raddr_b,
  output logic [7:0]       o_rdata_b
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata_a;
  logic [7:0] r_rdata_b;

  always_ff @(posedge CLK100MHZ) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the user port is reset so readback is defined right after reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) r_rdata_a <= 8'h00;
    else     r_rdata_a <= r_mem[i_raddr_a];
  end

  always_ff @(posedge CLK100MHZ) begin
    r_rdata_b <= r_mem[i_raddr_b];
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/sd_block_xfer.sv
// Multi-byte sector transfer engine between user logic and sd_spi_controller,
// with per-attempt timeout, bounded retry and sticky error codes.
module sd_block_xfer
  import sd_block_xfer_pkg::*;
#(
  parameter int          BUF_BYTES    = 16,
  parameter int          SECTOR_BYTES = 512,
  parameter int          ADDR_W       = 32,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int          TIMEOUT_CYC  = 100000000,
  parameter int          MAX_RETRY    = 2,
  localparam int         IDX_W        = idxWidth(BUF_BYTES)
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              start,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] blk_addr,
  input  logic              buf_wr_en,
  input  logic [IDX_W-1:0]  buf_wr_idx,
  input  logic [7:0]        buf_wr_data,
  input  logic [IDX_W-1:0]  buf_rd_idx,
  output logic [7:0]        buf_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              sd_init_done,
  input  logic              sd_busy,
  output logic              sd_rd_start,
  input  logic              sd_rd_valid,
  input  logic [7:0]        sd_rd_data,
  input  logic              sd_rd_done,
  output logic              sd_wr_start,
  input  logic              sd_wr_req,
  output logic [7:0]        sd_wr_data,
  input  logic              sd_wr_done,
  output logic [ADDR_W-1:0] sd_addr
);

  localparam int CNT_W = $clog2(SECTOR_BYTES + 1);
  localparam int TMO_W = idxWidth(TIMEOUT_CYC);
  localparam int RTY_W = idxWidth(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] BUF_CNT  = CNT_W'(BUF_BYTES);
  localparam logic [CNT_W-1:0] SECT_CNT = CNT_W'(SECTOR_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  err_t                r_err_code;
  logic                r_rd_start;
  logic                r_wr_start;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [TMO_W-1:0]    r_tmo;
  logic [RTY_W-1:0]    r_retry_cnt;

  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_ok;
  logic                w_fail;
  err_t                w_fail_code;
  logic                w_cap_en;
  logic                w_buf_we;
  logic [IDX_W-1:0]    w_buf_waddr;
  logic [7:0]          w_buf_wdata;
  logic [7:0]          w_wr_q;

  // Byte counter advances on accepted bytes and saturates at one sector,
  // so extra read valids are harmlessly ignored.
  always_comb begin
    w_cnt_next = r_byte_cnt;
    case (r_state)
      ST_ISSUE:   w_cnt_next = '0;
      ST_XFER_RD: if (sd_rd_valid && (r_byte_cnt < SECT_CNT)) w_cnt_next = r_byte_cnt + CNT_W'(1);
      ST_XFER_WR: if (sd_wr_req && (r_byte_cnt < SECT_CNT))   w_cnt_next = r_byte_cnt + CNT_W'(1);
      default:    w_cnt_next = r_byte_cnt;
    endcase
  end

  // Completion uses the post-increment count so a valid arriving with
  // rd_done is counted before the length check.
  always_comb begin
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    if (r_state == ST_XFER_RD) begin
      if (sd_rd_done) begin
        if (w_cnt_next == SECT_CNT) w_ok = 1'b1;
        else begin
          w_fail      = 1'b1;
          w_fail_code = ERR_SHORT;
        end
      end else if (r_tmo == TMO_LAST) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_TIMEOUT;
      end
    end else if (r_state == ST_XFER_WR) begin
      if (sd_wr_done) w_ok = 1'b1;
      else if (r_tmo == TMO_LAST) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_TIMEOUT;
      end
    end
  end

  assign w_cap_en    = (r_state == ST_XFER_RD) && sd_rd_valid && (r_byte_cnt < BUF_CNT);
  assign w_buf_we    = w_cap_en || (buf_wr_en && !r_busy);
  assign w_buf_waddr = w_cap_en ? r_byte_cnt[IDX_W-1:0] : buf_wr_idx;
  assign w_buf_wdata = w_cap_en ? sd_rd_data : buf_wr_data;

  sd_block_xfer_sector_buf #(
    .DEPTH (BUF_BYTES),
    .IDX_W (IDX_W)
  ) u_sector_buf (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .i_we      (w_buf_we),
    .i_waddr   (w_buf_waddr),
    .i_wdata   (w_buf_wdata),
    .i_raddr_a (buf_rd_idx),
    .o_rdata_a (buf_rd_data),
    .i_raddr_b (w_cnt_next[IDX_W-1:0]),
    .o_rdata_b (w_wr_q)
  );

  // Pulses default low each cycle and are raised only on the transition
  // into the state that owns them.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_rd_start  <= 1'b0;
      r_wr_start  <= 1'b0;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_byte_cnt  <= '0;
      r_tmo       <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_start <= 1'b0;
      r_wr_start <= 1'b0;
      r_byte_cnt <= w_cnt_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!sd_init_done) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_NOTRDY;
            end else begin
              r_is_write  <= is_write;
              r_addr      <= blk_addr;
              r_busy      <= 1'b1;
              r_err_code  <= ERR_NONE;
              r_retry_cnt <= '0;
              r_state     <= ST_WAIT_RDY;
            end
          end
        end
        ST_WAIT_RDY: begin
          if (!sd_busy) r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_tmo <= '0;
          if (r_is_write) begin
            r_wr_start <= 1'b1;
            r_state    <= ST_XFER_WR;
          end else begin
            r_rd_start <= 1'b1;
            r_state    <= ST_XFER_RD;
          end
        end
        ST_XFER_RD, ST_XFER_WR: begin
          if (w_ok) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_fail) begin
            r_err_code <= w_fail_code;
            if (r_retry_cnt < RTY_MAX) begin
              r_retry_cnt <= r_retry_cnt + RTY_W'(1);
              r_state     <= ST_RETRY;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_FAIL;
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_RETRY: r_state <= ST_WAIT_RDY;
        ST_DONE:  r_state <= ST_IDLE;
        ST_FAIL:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign sd_rd_start = r_rd_start;
  assign sd_wr_start = r_wr_start;
  assign sd_addr     = r_addr;
  // Both operands are registered, so the write byte is stable the cycle after a request.
  assign sd_wr_data  = (r_byte_cnt < BUF_CNT) ? w_wr_q : PAD_BYTE;

endmodule
